// File: rtl/dp_mem_responder.sv
// dp_mem_responder: memory-side responder for the datapath request protocol.
// Data and fetch requests share one single-port RAM. Data requests win.
// Each access goes IDLE -> DACC/IACC -> DONE. The DONE cycle carries a
// one-cycle hit pulse. A watchdog forces completion with ERR_WORD if the RAM
// never answers.
module dp_mem_responder #(
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] imemload,
    output logic [31:0] dmemload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2,
        DONE = 2'd3
    } state_t;

    // Last counter value allowed in an access state before the watchdog fires.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        ihit_q;
    logic        dhit_q;
    logic [31:0] imemload_q;
    logic [31:0] dmemload_q;
    logic        ramren_q;
    logic        ramwen_q;
    logic [31:0] ramaddr_q;
    logic [31:0] ramstore_q;
    logic        err_q;

    // Request decode evaluated while idle.
    logic        data_req_d;
    logic        conflict_d;
    logic [31:0] addr_d;
    logic        watchdog_d;

    // The low byte-offset bits are dropped when forming the word address.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{imemaddr[1:0], dmemaddr[1:0]};

    // Pick the winning request and its word-aligned address; flag watchdog expiry.
    always_comb begin
        data_req_d = dmemREN | dmemWEN;
        conflict_d = dmemREN & dmemWEN;
        addr_d     = data_req_d ? {dmemaddr[31:2], 2'b00} : {imemaddr[31:2], 2'b00};
        watchdog_d = (cnt_q == TIMEOUT_LAST);
    end

    // Access sequencer. All outputs are registered here.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            ihit_q     <= 1'b0;
            dhit_q     <= 1'b0;
            imemload_q <= 32'd0;
            dmemload_q <= 32'd0;
            ramren_q   <= 1'b0;
            ramwen_q   <= 1'b0;
            ramaddr_q  <= 32'd0;
            ramstore_q <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            ihit_q <= 1'b0;
            dhit_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= 8'd0;
                    if (data_req_d) begin
                        // A simultaneous read and write is treated as a write.
                        state_q    <= DACC;
                        ramaddr_q  <= addr_d;
                        ramstore_q <= dmemstore;
                        ramwen_q   <= dmemWEN;
                        ramren_q   <= ~dmemWEN;
                        if (conflict_d) begin
                            err_q <= 1'b1;
                        end
                    end else if (imemREN) begin
                        state_q   <= IACC;
                        ramaddr_q <= addr_d;
                        ramren_q  <= 1'b1;
                        ramwen_q  <= 1'b0;
                    end
                end
                DACC, IACC: begin
                    if (ramready || watchdog_d) begin
                        state_q  <= DONE;
                        cnt_q    <= 8'd0;
                        ramren_q <= 1'b0;
                        ramwen_q <= 1'b0;
                        if (!ramready) begin
                            err_q <= 1'b1;
                        end
                        if (state_q == IACC) begin
                            ihit_q     <= 1'b1;
                            imemload_q <= ramready ? ramload : ERR_WORD;
                        end else begin
                            dhit_q <= 1'b1;
                            // Writes leave the last read value in place.
                            if (!ramwen_q) begin
                                dmemload_q <= ramready ? ramload : ERR_WORD;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    cnt_q   <= 8'd0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign imemload = imemload_q;
    assign dmemload = dmemload_q;
    assign ramREN   = ramren_q;
    assign ramWEN   = ramwen_q;
    assign ramaddr  = ramaddr_q;
    assign ramstore = ramstore_q;
    assign err      = err_q;

endmodule

// File: doc/dp_mem_responder.md
Name: dp_mem_responder

Overview:
- Memory-side responder for the datapath_cache_if request protocol. It accepts instruction fetches (imemREN/imemaddr) and data reads/writes (dmemREN/dmemWEN/dmemaddr/dmemstore) from the datapath.
- It serializes these requests onto one single-port RAM and returns ihit/dhit with imemload/dmemload.
- It sits between the datapath and the RAM model, in place of a cache.
- Data requests take priority over fetches. A watchdog counter bounds every RAM access.

Parameters:
- TIMEOUT, 64: max cycles in a RAM access state before forced completion; legal range 2..255.
- ERR_WORD, 32'hBAD1BAD1: load value returned on a timed-out access.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- imemREN  in  1  instruction fetch request.
- imemaddr  in  32  fetch byte address.
- dmemREN  in  1  data read request.
- dmemWEN  in  1  data write request.
- dmemaddr  in  32  data byte address.
- dmemstore  in  32  write data.
- ihit  out  1  one-cycle pulse: fetch complete, imemload valid.
- dhit  out  1  one-cycle pulse: data access complete, dmemload valid (reads).
- imemload  out  32  fetched instruction, registered.
- dmemload  out  32  read data, registered.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM word address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data, valid when ramready=1.
- ramready  in  1  RAM access complete this cycle.
- err  out  1  sticky error flag.

Behaviour:
- Reset: all outputs 0 on the first rising edge with RST=1, including ihit, dhit, imemload, dmemload, ram* and err. State becomes IDLE and the counter is 0. Reset taken mid-access abandons the access; RAM strobes are 0 from the next cycle and no hit is issued.
- FSM states: IDLE, DACC, IACC, DONE.
- IDLE:
  - Samples requests.
  - dmemREN|dmemWEN goes to DACC; else imemREN goes to IACC; else stays in IDLE.
  - On leaving IDLE, latches the address (ramaddr = {addr[31:2],2'b00}), kind (read/write) and store data into request registers.
  - RAM strobes are never asserted in IDLE.
- Both dmemREN and dmemWEN high: treated as a write; err set.
- DACC / IACC:
  - ramREN (read) or ramWEN (dmem write) is held at 1 and ramaddr/ramstore are held stable from the latched registers. Later input changes are ignored.
  - Counter increments each cycle.
  - ramready=1: capture ramload into dmemload (DACC read) or imemload (IACC); go to DONE.
  - Counter reaches TIMEOUT-1 without ramready: load ERR_WORD instead, set err, go to DONE.
- DONE:
  - Exactly one cycle. RAM strobes 0.
  - dhit=1 (from DACC) or ihit=1 (from IACC); never both.
  - Counter cleared. Returns to IDLE.
- Latency: request seen in IDLE at cycle t; RAM strobe active from t+1; ramready at t+k; hit at t+k+1; next request sampled at t+k+2. Minimum 3 cycles per access, back to back.
- Requester dropping its request mid-access: the RAM access still completes and the hit still pulses. The requester ignores it.
- imemload/dmemload hold their last value until the next matching completion. dmemload is unchanged on writes.
- Starvation: a continuously asserted dmem request blocks fetches. This is intended, since the datapath stalls the PC on data accesses.
- err clears only on RST.

Test Plan:
- Reset: hold RST 2 cycles with all requests high -> all outputs 0; first request serviced only after RST=0.
- Single fetch:
  - Stimulus: imemREN=1, imemaddr=32'h0000_0047; RAM returns ramready after 2 cycles with ramload=32'h2001_0005.
  - Required: ramaddr=32'h44 and ramREN=1 for exactly 2 cycles; ihit pulses once; imemload=32'h2001_0005.
- Priority:
  - Stimulus: imemREN=1 and dmemREN=1 (dmemaddr=32'h100) in the same IDLE cycle.
  - Required: the data read is serviced first and dhit fires; the fetch is serviced next and ihit fires; no cycle has ihit and dhit both high.
- Write:
  - Stimulus: dmemWEN=1, dmemaddr=32'h200, dmemstore=32'hDEAD_BEEF, with inputs changed during the access.
  - Required: ramWEN=1, ramaddr=32'h200, ramstore=32'hDEAD_BEEF stay stable; dhit pulses once; dmemload unchanged; ramREN stays 0.
- Timeout:
  - Stimulus: ramready tied 0 with TIMEOUT=8.
  - Required: ramREN high exactly 8 cycles; ihit then pulses with imemload=32'hBAD1BAD1; err=1 and stays 1 until RST.
- Reset mid-access:
  - Stimulus: assert RST on the 2nd cycle of DACC.
  - Required: ramREN=0 and dhit=0 on the following cycle; state IDLE; a later ramready pulse has no effect.
